// File: rtl/fft_stream_sched.sv
// fft_stream_sched: scheduler for the fftmain -> LPF -> ifftmain streaming chain.
// Accepts samples on a valid/ready stream and issues the single clock enable that
// advances the chain. The LPF cutoff is applied only at frame boundaries, and a
// stop drains the pipeline with zero frames. The IFFT output is qualified
// against frame sync. Configuration and status go through a 16-bit register port.
// Ports:
//   i_clk, i_reset_n               clock, synchronous active-low reset
//   s_valid/s_ready/s_sample       input sample stream {re,im}
//   o_ce/o_sample                  chain clock enable and sample to fftmain
//   o_cutoff                       LPF cutoff bin
//   i_out_ce/i_sync/i_result       IFFT output strobe, frame sync and data
//   m_valid/m_sof/m_result         qualified output stream
//   address/write/writedata        register write port
//   read/readdata                  register read port (1-cycle latency)
module fft_stream_sched #(
  parameter int unsigned IWIDTH       = 16,
  parameter int unsigned OWIDTH       = 26,
  parameter int unsigned LGWIDTH      = 9,
  parameter int unsigned FLUSH_FRAMES = 3,
  parameter int unsigned CUTOFF_RST   = 10
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [2*IWIDTH-1:0]   s_sample,
  output logic                  o_ce,
  output logic [2*IWIDTH-1:0]   o_sample,
  output logic [LGWIDTH-1:0]    o_cutoff,
  input  logic                  i_out_ce,
  input  logic                  i_sync,
  input  logic [2*OWIDTH-1:0]   i_result,
  output logic                  m_valid,
  output logic                  m_sof,
  output logic [2*OWIDTH-1:0]   m_result,
  input  logic [1:0]            address,
  input  logic                  write,
  input  logic [15:0]           writedata,
  input  logic                  read,
  output logic [15:0]           readdata
);

  localparam int unsigned SW        = 2 * IWIDTH;
  localparam int unsigned RW        = 2 * OWIDTH;
  localparam int unsigned FLUSH_LEN = FLUSH_FRAMES << LGWIDTH;
  localparam int unsigned FW        = $clog2(FLUSH_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STOP  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_enable;
  logic [LGWIDTH-1:0]  r_shadow;
  logic [LGWIDTH-1:0]  r_incnt;
  logic [FW-1:0]       r_flush_cnt;
  logic                r_synced;
  logic [15:0]         r_frames;
  logic                r_s_ready;
  logic                r_o_ce;
  logic [SW-1:0]       r_o_sample;
  logic [LGWIDTH-1:0]  r_o_cutoff;
  logic                r_m_valid;
  logic                r_m_sof;
  logic [RW-1:0]       r_m_result;
  logic [15:0]         r_readdata;

  logic                w_accept;
  logic                w_wrap;
  logic                w_flush_done;
  logic                w_unused;

  assign w_accept     = s_valid && r_s_ready;
  assign w_wrap       = w_accept && (&r_incnt);
  assign w_flush_done = (r_flush_cnt == FW'(FLUSH_LEN - 1));
  assign w_unused     = ^writedata[15:LGWIDTH];

  // Next-state logic; a stop with no frame in progress skips straight to flush.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (r_enable) w_next = RUN;
      RUN: begin
        if (!r_enable) begin
          if (w_wrap || ((r_incnt == '0) && !w_accept)) w_next = FLUSH;
          else                                           w_next = STOP;
        end
      end
      STOP:  if (w_wrap) w_next = FLUSH;
      FLUSH: if (w_flush_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register and input-side datapath.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_s_ready   <= 1'b0;
      r_o_ce      <= 1'b0;
      r_o_sample  <= '0;
      r_o_cutoff  <= LGWIDTH'(CUTOFF_RST);
      r_incnt     <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state   <= w_next;
      // Ready is registered from the next state so it lines up with the state it belongs to.
      r_s_ready <= (w_next == RUN) || (w_next == STOP);
      r_o_ce    <= 1'b0;
      if (w_accept) begin
        r_o_ce     <= 1'b1;
        r_o_sample <= s_sample;
        r_incnt    <= r_incnt + LGWIDTH'(1);
      end
      if (r_state == FLUSH) begin
        r_o_ce      <= 1'b1;
        r_o_sample  <= '0;
        r_flush_cnt <= w_flush_done ? '0 : r_flush_cnt + FW'(1);
      end
      // Cutoff tracks the shadow freely while idle, otherwise only at a frame boundary.
      if ((r_state == IDLE) || w_wrap) r_o_cutoff <= r_shadow;
    end
  end

  // Register port.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_enable   <= 1'b0;
      r_shadow   <= LGWIDTH'(CUTOFF_RST);
      r_readdata <= '0;
    end else begin
      if (write) begin
        case (address)
          2'd0:    r_enable <= writedata[0];
          2'd1:    r_shadow <= writedata[LGWIDTH-1:0];
          default: ;
        endcase
      end
      if (read) begin
        case (address)
          2'd0:    r_readdata <= {15'd0, r_enable};
          2'd1:    r_readdata <= 16'(r_shadow);
          2'd2:    r_readdata <= {13'd0, r_synced, r_state};
          default: r_readdata <= r_frames;
        endcase
      end
    end
  end

  // Output qualification; synced latches on the first framed output strobe.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_synced   <= 1'b0;
      r_frames   <= '0;
      r_m_valid  <= 1'b0;
      r_m_sof    <= 1'b0;
      r_m_result <= '0;
    end else begin
      if (i_out_ce && i_sync) begin
        r_synced <= 1'b1;
        r_frames <= r_frames + 16'd1;
      end
      r_m_valid  <= i_out_ce && (r_synced || i_sync);
      r_m_sof    <= i_out_ce && i_sync;
      r_m_result <= i_result;
    end
  end

  assign s_ready  = r_s_ready;
  assign o_ce     = r_o_ce;
  assign o_sample = r_o_sample;
  assign o_cutoff = r_o_cutoff;
  assign m_valid  = r_m_valid;
  assign m_sof    = r_m_sof;
  assign m_result = r_m_result;
  assign readdata = r_readdata;

endmodule

// File: tb/tb_fft_stream_sched.sv
// Testbench for fft_stream_sched: scenario tasks with a scoreboard queue for the
// chain-side sample stream and one for the qualified output stream.
`timescale 1ns/1ps
module tb_fft_stream_sched;

  localparam int unsigned IW    = 16;
  localparam int unsigned OW    = 26;
  localparam int unsigned LG    = 9;
  localparam int unsigned FRAME = 1 << LG;
  localparam int unsigned FLEN  = 3 * FRAME;

  logic              i_clk = 1'b0;
  logic              i_reset_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [2*IW-1:0]   s_sample = '0;
  logic              o_ce;
  logic [2*IW-1:0]   o_sample;
  logic [LG-1:0]     o_cutoff;
  logic              i_out_ce = 1'b0;
  logic              i_sync = 1'b0;
  logic [2*OW-1:0]   i_result = '0;
  logic              m_valid;
  logic              m_sof;
  logic [2*OW-1:0]   m_result;
  logic [1:0]        address = '0;
  logic              write = 1'b0;
  logic [15:0]       writedata = '0;
  logic              read = 1'b0;
  logic [15:0]       readdata;

  fft_stream_sched dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_sample(s_sample),
    .o_ce(o_ce), .o_sample(o_sample), .o_cutoff(o_cutoff),
    .i_out_ce(i_out_ce), .i_sync(i_sync), .i_result(i_result),
    .m_valid(m_valid), .m_sof(m_sof), .m_result(m_result),
    .address(address), .write(write), .writedata(writedata),
    .read(read), .readdata(readdata)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Chain-side scoreboard: every accepted sample (and every expected flush zero)
  // must appear on o_ce/o_sample, in order, with no extra o_ce pulses.
  logic [2*IW-1:0] exp_q[$];
  logic [2*IW-1:0] exp_s;
  logic            mon_en = 1'b0;
  int              ce_count = 0;
  int              tb_incnt = 0;
  logic [LG-1:0]   tb_shadow = LG'(10);
  logic [LG-1:0]   tb_cut_exp = LG'(10);

  typedef struct packed {
    logic          valid;
    logic          sof;
    logic [2*OW-1:0] result;
  } mexp_t;
  mexp_t m_q[$];

  always @(negedge i_clk) begin
    if (mon_en) begin
      checks++;
      if (o_ce === 1'b1) ce_count++;
      if (exp_q.size() == 0) begin
        if (o_ce !== 1'b0) begin
          errors++;
          $display("FAIL o_ce_unexpected: got %b want 0 at %0t", o_ce, $time);
        end
      end else begin
        exp_s = exp_q.pop_front();
        if (o_ce !== 1'b1 || o_sample !== exp_s) begin
          errors++;
          $display("FAIL o_sample: got ce=%b %h want ce=1 %h at %0t", o_ce, o_sample, exp_s, $time);
        end
      end
      if (s_valid && s_ready) exp_q.push_back(s_sample);
    end
  end

  task automatic reg_write(input logic [1:0] a, input logic [15:0] d);
    address = a; writedata = d; write = 1'b1;
    @(posedge i_clk); #1;
    write = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [15:0] d);
    address = a; read = 1'b1;
    @(posedge i_clk); #1;
    read = 1'b0;
    d = readdata;
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (s_ready !== 1'b1 && guard < 50) begin
      @(posedge i_clk); #1; guard++;
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready_timeout: got s_ready=%b want 1", s_ready);
    end
  endtask

  // Streams n accepted samples; tracks frame position and checks o_cutoff each cycle.
  task automatic send_samples(input int n);
    int   sent = 0;
    int   guard = 0;
    logic rdy;
    while (sent < n && guard < 4 * n + 100) begin
      s_valid = 1'b1; s_sample = $urandom; rdy = s_ready;
      @(posedge i_clk); #1;
      guard++;
      if (rdy) begin
        sent++;
        tb_incnt = (tb_incnt + 1) % FRAME;
        if (tb_incnt == 0) tb_cut_exp = tb_shadow;
      end
      checks++;
      if (o_cutoff !== tb_cut_exp) begin
        errors++;
        $display("FAIL o_cutoff: got %0d want %0d (incnt %0d)", o_cutoff, tb_cut_exp, tb_incnt);
      end
    end
    s_valid = 1'b0;
    checks++;
    if (sent != n) begin
      errors++;
      $display("FAIL send_timeout: sent %0d want %0d", sent, n);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < FLEN + 100) begin
      @(posedge i_clk); #1; guard++;
    end
    @(posedge i_clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d outstanding want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    logic [15:0] d;
    logic [15:0] exp_regs [4];
    exp_regs[0] = 16'd0; exp_regs[1] = 16'd10; exp_regs[2] = 16'd0; exp_regs[3] = 16'd0;
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if (s_ready !== 1'b0 || o_ce !== 1'b0 || m_valid !== 1'b0 || m_sof !== 1'b0 ||
        o_cutoff !== LG'(10) || readdata !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b ce=%b mv=%b sof=%b cut=%0d rd=%h want 0,0,0,0,10,0",
               s_ready, o_ce, m_valid, m_sof, o_cutoff, readdata);
    end
    i_reset_n = 1'b1;
    mon_en = 1'b1;
    for (int r = 0; r < 4; r++) begin
      reg_read(2'(r), d);
      checks++;
      if (d !== exp_regs[r]) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h want %h", r, d, exp_regs[r]);
      end
    end
    s_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      s_sample = $urandom;
      @(posedge i_clk); #1;
      checks++;
      if (s_ready !== 1'b0 || o_ce !== 1'b0) begin
        errors++;
        $display("FAIL idle_stall: got rdy=%b ce=%b want 0,0", s_ready, o_ce);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_frame();
    logic [15:0] d;
    reg_write(2'd0, 16'd1);
    wait_ready();
    ce_count = 0;
    send_samples(FRAME);
    @(posedge i_clk); #1;
    checks++;
    if (ce_count != FRAME) begin
      errors++;
      $display("FAIL frame_ce_count: got %0d want %0d", ce_count, FRAME);
    end
    reg_read(2'd2, d);
    checks++;
    if (d !== 16'd1) begin
      errors++;
      $display("FAIL status_run: got %h want 0001", d);
    end
  endtask

  task automatic test_gap();
    int lows = 0;
    send_samples(100);
    for (int g = 0; g < 5; g++) begin
      @(posedge i_clk); #1;
      if (o_ce === 1'b0) lows++;
    end
    checks++;
    if (lows != 5) begin
      errors++;
      $display("FAIL gap_ce_low: got %0d low cycles want 5", lows);
    end
  endtask

  task automatic test_cutoff();
    reg_write(2'd1, 16'd20);
    tb_shadow = LG'(20);
    send_samples(FRAME - 100);
    checks++;
    if (o_cutoff !== LG'(20)) begin
      errors++;
      $display("FAIL cutoff_applied: got %0d want 20", o_cutoff);
    end
  endtask

  task automatic test_stop_flush();
    logic [15:0] d;
    int accepts = 0;
    int guard = 0;
    send_samples(300);
    reg_write(2'd0, 16'd0);
    @(posedge i_clk); #1;
    ce_count = 0;
    while (s_ready === 1'b1 && guard < 1000) begin
      s_valid = 1'b1; s_sample = $urandom;
      @(posedge i_clk); #1;
      accepts++; guard++;
    end
    s_valid = 1'b0;
    tb_incnt = 0;
    checks++;
    if (accepts != FRAME - 300) begin
      errors++;
      $display("FAIL stop_accepts: got %0d want %0d", accepts, FRAME - 300);
    end
    for (int z = 0; z < FLEN; z++) exp_q.push_back('0);
    reg_read(2'd2, d);
    checks++;
    if (d !== 16'd3 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL status_flush: got %h rdy=%b want 0003 rdy=0", d, s_ready);
    end
    drain();
    checks++;
    if (ce_count != FRAME - 300 + FLEN) begin
      errors++;
      $display("FAIL flush_ce_count: got %0d want %0d", ce_count, FRAME - 300 + FLEN);
    end
    reg_read(2'd2, d);
    checks++;
    if (d !== 16'd0) begin
      errors++;
      $display("FAIL status_idle: got %h want 0000", d);
    end
  endtask

  task automatic test_output_sync();
    logic [15:0] d;
    logic        tb_synced = 1'b0;
    logic [1:0]  pat [10];
    mexp_t       e;
    int          sofs = 0;
    pat[0] = 2'b10; pat[1] = 2'b01; pat[2] = 2'b11; pat[3] = 2'b10; pat[4] = 2'b00;
    pat[5] = 2'b11; pat[6] = 2'b10; pat[7] = 2'b11; pat[8] = 2'b10; pat[9] = 2'b00;
    for (int k = 0; k < 10; k++) begin
      i_out_ce = pat[k][1]; i_sync = pat[k][0];
      i_result = {$urandom, $urandom};
      e.valid  = i_out_ce && (tb_synced || i_sync);
      e.sof    = i_out_ce && i_sync;
      e.result = i_result;
      if (i_out_ce && i_sync) tb_synced = 1'b1;
      m_q.push_back(e);
      @(posedge i_clk); #1;
      e = m_q.pop_front();
      if (m_sof === 1'b1) sofs++;
      checks++;
      if (m_valid !== e.valid || m_sof !== e.sof || m_result !== e.result) begin
        errors++;
        $display("FAIL m_out[%0d]: got v=%b sof=%b %h want v=%b sof=%b %h",
                 k, m_valid, m_sof, m_result, e.valid, e.sof, e.result);
      end
    end
    i_out_ce = 1'b0; i_sync = 1'b0;
    checks++;
    if (sofs != 3) begin
      errors++;
      $display("FAIL sof_count: got %0d want 3", sofs);
    end
    reg_read(2'd3, d);
    checks++;
    if (d !== 16'd3) begin
      errors++;
      $display("FAIL frame_count: got %0d want 3", d);
    end
    reg_read(2'd2, d);
    checks++;
    if (d !== 16'd4) begin
      errors++;
      $display("FAIL status_synced: got %h want 0004", d);
    end
  endtask

  task automatic test_reset_in_flush();
    logic [15:0] d;
    mon_en = 1'b0;
    reg_write(2'd0, 16'd1);
    wait_ready();
    reg_write(2'd0, 16'd0);
    repeat (4) @(posedge i_clk);
    #1;
    reg_read(2'd2, d);
    checks++;
    if (d !== 16'd7 || o_ce !== 1'b1) begin
      errors++;
      $display("FAIL status_flush_synced: got %h ce=%b want 0007 ce=1", d, o_ce);
    end
    i_reset_n = 1'b0; i_out_ce = 1'b1; i_sync = 1'b1; i_result = {$urandom, $urandom};
    @(posedge i_clk); #1;
    checks++;
    if (s_ready !== 1'b0 || o_ce !== 1'b0 || m_valid !== 1'b0 || m_sof !== 1'b0 ||
        o_sample !== '0 || m_result !== '0 || readdata !== 16'd0 || o_cutoff !== LG'(10)) begin
      errors++;
      $display("FAIL reset_in_flush: got rdy=%b ce=%b mv=%b sof=%b os=%h mr=%h rd=%h cut=%0d want zeros cut=10",
               s_ready, o_ce, m_valid, m_sof, o_sample, m_result, readdata, o_cutoff);
    end
    i_reset_n = 1'b1; i_out_ce = 1'b0; i_sync = 1'b0;
    reg_read(2'd2, d);
    checks++;
    if (d !== 16'd0) begin
      errors++;
      $display("FAIL status_after_reset: got %h want 0000", d);
    end
    reg_read(2'd3, d);
    checks++;
    if (d !== 16'd0) begin
      errors++;
      $display("FAIL frames_after_reset: got %h want 0000", d);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_gap();
    test_cutoff();
    test_stop_flush();
    test_output_sync();
    test_reset_in_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
